// File: rtl/mem_subword_ctrl.sv
// MEM-stage access sequencer for a word-only synchronous data memory.
// Sub-word loads are extracted from the read word; sub-word stores run read-modify-write.
module mem_subword_ctrl #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        fault_q, fault_d;

    logic        bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Classification of the incoming request; stores only know b/h/w.
    always_comb begin
        bad = 1'b1;
        case (funct3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr[0];
            3'b010:  bad = |addr[1:0];
            3'b100:  bad = we;
            3'b101:  bad = we | addr[0];
            default: bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            funct3_q <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        funct3_d = funct3_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        fault_d  = fault_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d   = addr;
                    wdata_d  = wdata;
                    funct3_d = funct3;
                    we_d     = we;
                    fault_d  = bad;
                    if (bad) begin
                        state_d = DONE;
                    end else if (we && funct3 == 3'b010) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                cnt_d   = 3'(READ_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    word_d  = mem_rdata;
                    state_d = we_q ? WR : DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR: begin
                state_d = DONE;
            end
            DONE: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
        half_sel = word_q[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = word_q;
        endcase
    end

    // Store lanes overlay the captured word; a word store ignores it.
    always_comb begin
        merged = word_q;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        done      = (state_q == DONE);
        fault     = (state_q == DONE) & fault_q;
        mem_re    = (state_q == RD);
        mem_we    = (state_q == WR);
        mem_wdata = (state_q == WR) ? merged : 32'h0;
        mem_addr  = (state_q != IDLE) ? {addr_q[31:2], 2'b00} : 32'h0;
        rdata     = (state_q == DONE && !fault_q && !we_q) ? load_val : 32'h0;
        stall     = ~reset & (((state_q == IDLE) & req) |
                              (state_q == RD) |
                              (state_q == WAIT) |
                              (state_q == WR));
    end

endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Randomized bench for mem_subword_ctrl at READ_LAT=1 and READ_LAT=3,
// each instance backed by its own latency-accurate word memory.
module tb_mem_subword_ctrl;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_s      [2];
    logic        we_s       [2];
    logic [2:0]  f3_s       [2];
    logic [31:0] addr_s     [2];
    logic [31:0] wdata_s    [2];
    logic [31:0] rdata_s    [2];
    logic        done_s     [2];
    logic        fault_s    [2];
    logic        stall_s    [2];
    logic [31:0] mem_addr_s [2];
    logic        mem_re_s   [2];
    logic        mem_we_s   [2];
    logic [31:0] mem_wdata_s[2];
    logic [31:0] mem_rdata_s[2];

    logic [31:0] mem    [2][64];
    logic [31:0] refmem [2][64];
    logic [31:0] pipe   [2][4];
    int          lat    [2] = '{LAT0, LAT1};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_subword_ctrl #(.READ_LAT(LAT0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]),
        .funct3(f3_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .rdata(rdata_s[0]), .done(done_s[0]), .fault(fault_s[0]),
        .stall(stall_s[0]), .mem_addr(mem_addr_s[0]), .mem_re(mem_re_s[0]),
        .mem_we(mem_we_s[0]), .mem_wdata(mem_wdata_s[0]),
        .mem_rdata(mem_rdata_s[0])
    );

    mem_subword_ctrl #(.READ_LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]),
        .funct3(f3_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .rdata(rdata_s[1]), .done(done_s[1]), .fault(fault_s[1]),
        .stall(stall_s[1]), .mem_addr(mem_addr_s[1]), .mem_re(mem_re_s[1]),
        .mem_we(mem_we_s[1]), .mem_wdata(mem_wdata_s[1]),
        .mem_rdata(mem_rdata_s[1])
    );

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we_s[d]) mem[d][mem_addr_s[d][7:2]] = mem_wdata_s[d];
        end
    end

    // Read data appears exactly READ_LAT cycles after the strobe, poison otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pipe[d][0] <= mem_re_s[d] ? mem[d][mem_addr_s[d][7:2]] : POISON;
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
    end

    assign mem_rdata_s[0] = pipe[0][LAT0-1];
    assign mem_rdata_s[1] = pipe[1][LAT1-1];

    function automatic bit ref_fault(input logic w, input logic [2:0] f,
                                     input logic [31:0] a);
        int fi;
        fi = int'(f);
        if (w && fi > 2) return 1'b1;
        if (!w && !(fi inside {0, 1, 2, 4, 5})) return 1'b1;
        if ((fi == 1 || fi == 5) && (a % 2) != 0) return 1'b1;
        if (fi == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word,
                                             input logic [2:0] f,
                                             input logic [31:0] a);
        longint v;
        longint w64;
        int b;
        w64 = {32'h0, word};
        b = int'(a % 4);
        case (f)
            3'b000, 3'b100: begin
                v = (w64 >> (8 * b)) & 255;
                if (f == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = (w64 >> (16 * (b / 2))) & 65535;
                if (f == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = w64;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old,
                                              input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] wd);
        longint mask;
        longint val;
        longint one;
        int lane;
        int nb;
        one = 1;
        nb = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
        lane = (f == 3'b000) ? int'(a % 4) :
               (f == 3'b001) ? 2 * int'((a % 4) / 2) : 0;
        mask = ((one << (8 * nb)) - 1) << (8 * lane);
        val = ({32'h0, old} & ~mask) | (({32'h0, wd} << (8 * lane)) & mask);
        return val[31:0];
    endfunction

    task automatic do_op(input int d, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd_o, output logic [31:0] wd_o);
        int wi, dk, nre, nwe, explat, expre, expwe;
        bit flt, stall_ok, fl_seen, st_done;
        logic [31:0] old, exp_word, exp_rd, we_addr, exp_addr;
        wi = int'(a[7:2]);
        old = refmem[d][wi];
        flt = ref_fault(w, f, a);
        exp_word = old;
        exp_rd = 32'h0;
        exp_addr = {a[31:2], 2'b00};
        expre = 0;
        expwe = 0;
        explat = 1;
        if (!flt && w) begin
            exp_word = ref_store(old, f, a, wd);
            expwe = 1;
            if (f == 3'b010) begin
                explat = 2;
            end else begin
                explat = lat[d] + 3;
                expre = 1;
            end
        end else if (!flt) begin
            exp_rd = ref_load(old, f, a);
            explat = lat[d] + 2;
            expre = 1;
        end
        dk = -1; nre = 0; nwe = 0; stall_ok = 1'b1;
        fl_seen = 1'b0; st_done = 1'b0;
        rd_o = 32'h0; wd_o = 32'h0; we_addr = 32'h0;
        @(posedge clk); #1;
        req_s[d] = 1'b1; we_s[d] = w; f3_s[d] = f;
        addr_s[d] = a; wdata_s[d] = wd;
        for (int k = 0; k < 16 && dk < 0; k++) begin
            @(negedge clk);
            if (mem_re_s[d]) nre++;
            if (mem_we_s[d]) begin
                nwe++;
                we_addr = mem_addr_s[d];
                wd_o = mem_wdata_s[d];
            end
            if (done_s[d]) begin
                dk = k;
                rd_o = rdata_s[d];
                fl_seen = fault_s[d];
                st_done = stall_s[d];
            end else if (!stall_s[d]) begin
                stall_ok = 1'b0;
            end
            if (k == 0) begin
                @(posedge clk); #1;
                req_s[d] = 1'b0;
                addr_s[d] = $urandom;
                wdata_s[d] = $urandom;
                we_s[d] = 1'($urandom);
                f3_s[d] = 3'($urandom);
            end
        end
        checks++;
        if (dk !== explat) begin
            failures++;
            $display("FAIL latency d=%0d we=%0d f3=%0d a=%0d got=%0d exp=%0d",
                     d, w, f, a, dk, explat);
        end
        checks++;
        if (fl_seen !== flt) begin
            failures++;
            $display("FAIL fault d=%0d f3=%0d a=%0d got=%0d exp=%0d", d, f, a, fl_seen, flt);
        end
        checks++;
        if (!stall_ok || st_done) begin
            failures++;
            $display("FAIL stall d=%0d f3=%0d a=%0d busy_ok=%0d at_done=%0d exp=1/0",
                     d, f, a, stall_ok, st_done);
        end
        checks++;
        if (nre !== expre || nwe !== expwe) begin
            failures++;
            $display("FAIL strobes d=%0d f3=%0d a=%0d re=%0d we=%0d exp re=%0d we=%0d",
                     d, f, a, nre, nwe, expre, expwe);
        end
        if (!w) begin
            checks++;
            if (rd_o !== exp_rd) begin
                failures++;
                $display("FAIL rdata d=%0d f3=%0d a=%0d got=%h exp=%h", d, f, a, rd_o, exp_rd);
            end
        end
        if (expwe == 1) begin
            checks++;
            if (wd_o !== exp_word || we_addr !== exp_addr) begin
                failures++;
                $display("FAIL mem_write d=%0d f3=%0d a=%0d got=%h@%h exp=%h@%h",
                         d, f, a, wd_o, we_addr, exp_word, exp_addr);
            end
        end
        checks++;
        if (mem[d][wi] !== exp_word) begin
            failures++;
            $display("FAIL mem_word d=%0d idx=%0d got=%h exp=%h", d, wi, mem[d][wi], exp_word);
        end
        refmem[d][wi] = exp_word;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rdata_s[d], done_s[d], fault_s[d], stall_s[d], mem_re_s[d],
                 mem_we_s[d], mem_addr_s[d], mem_wdata_s[d]} !== 100'h0) begin
                failures++;
                $display("FAIL reset_outputs d=%0d got rdata=%h done=%0d fault=%0d stall=%0d re=%0d we=%0d addr=%h wdata=%h exp all 0",
                         d, rdata_s[d], done_s[d], fault_s[d], stall_s[d],
                         mem_re_s[d], mem_we_s[d], mem_addr_s[d], mem_wdata_s[d]);
            end
        end
    endtask

    task automatic test_loads();
        logic [31:0] la [7] = '{96, 97, 98, 99, 99, 98, 96};
        logic [2:0]  lf [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] le [7] = '{32'hFFFFFFDD, 32'hFFFFFFC0, 32'h0000000B, 32'hFFFFFFAA,
                                32'h000000AA, 32'hFFFFAA0B, 32'h0000C0DD};
        logic [31:0] rd, wd;
        for (int i = 0; i < 7; i++) begin
            do_op(0, 1'b0, lf[i], la[i], 32'h0, rd, wd);
            checks++;
            if (rd !== le[i]) begin
                failures++;
                $display("FAIL plan_load i=%0d got=%h exp=%h", i, rd, le[i]);
            end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd, wd;
        do_op(0, 1'b1, 3'b000, 32'd99, 32'h12345633, rd, wd);
        checks++;
        if (wd !== 32'h330BC0DD) begin
            failures++;
            $display("FAIL plan_sb got=%h exp=%h", wd, 32'h330BC0DD);
        end
        do_op(0, 1'b1, 3'b001, 32'd98, 32'h0000BEEF, rd, wd);
        checks++;
        if (wd !== 32'hBEEFC0DD) begin
            failures++;
            $display("FAIL plan_sh got=%h exp=%h", wd, 32'hBEEFC0DD);
        end
        do_op(0, 1'b1, 3'b010, 32'd100, 32'hCAFEF00D, rd, wd);
        checks++;
        if (wd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL plan_sw got=%h exp=%h", wd, 32'hCAFEF00D);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd, wd;
        do_op(0, 1'b0, 3'b010, 32'd98, 32'h0, rd, wd);
        do_op(0, 1'b0, 3'b001, 32'd97, 32'h0, rd, wd);
        do_op(0, 1'b0, 3'b011, 32'd96, 32'h0, rd, wd);
        do_op(1, 1'b1, 3'b101, 32'd96, 32'h55AA55AA, rd, wd);
    endtask

    task automatic test_lat3();
        logic [31:0] rd, wd;
        do_op(1, 1'b0, 3'b010, 32'd96, 32'h0, rd, wd);
        checks++;
        if (rd !== 32'hAA0BC0DD) begin
            failures++;
            $display("FAIL plan_lat3 got=%h exp=%h", rd, 32'hAA0BC0DD);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, wd, old;
        old = refmem[1][24];
        @(posedge clk); #1;
        req_s[1] = 1'b1; we_s[1] = 1'b1; f3_s[1] = 3'b000;
        addr_s[1] = 32'd99; wdata_s[1] = 32'h00000077;
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we_s[1] !== 1'b0) begin
                failures++;
                $display("FAIL abort_we cyc=%0d got=%0d exp=0", i, mem_we_s[1]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (mem[1][24] !== old) begin
            failures++;
            $display("FAIL abort_mem got=%h exp=%h", mem[1][24], old);
        end
        do_op(1, 1'b0, 3'b010, 32'd96, 32'h0, rd, wd);
        checks++;
        if (rd !== old) begin
            failures++;
            $display("FAIL abort_reload got=%h exp=%h", rd, old);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, wd;
        logic [7:0] b;
        for (int d = 0; d < 2; d++) begin
            b = 8'($urandom);
            do_op(d, 1'b1, 3'b000, 32'd41, {24'h0, b}, rd, wd);
            do_op(d, 1'b0, 3'b100, 32'd41, 32'h0, rd, wd);
            checks++;
            if (rd !== {24'h0, b}) begin
                failures++;
                $display("FAIL b2b d=%0d got=%h exp=%h", d, rd, {24'h0, b});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, a;
        logic [2:0] f;
        logic w;
        for (int n = 0; n < 80; n++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            if (w && $urandom_range(0, 3) != 0) f = {1'b0, f[1:0]};
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'b01) a[0] = 1'b0;
                else if (f[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_op(n % 2, w, f, a, $urandom, rd, wd);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = 1'b0; we_s[d] = 1'b0; f3_s[d] = 3'b0;
            addr_s[d] = 32'h0; wdata_s[d] = 32'h0;
            for (int i = 0; i < 64; i++) begin
                mem[d][i] = $urandom;
                refmem[d][i] = mem[d][i];
            end
            mem[d][24] = 32'hAA0BC0DD;
            refmem[d][24] = 32'hAA0BC0DD;
        end
        #2;
        test_reset();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        test_loads();
        test_stores();
        test_faults();
        test_lat3();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_subword_ctrl.md
Name: mem_subword_ctrl

Overview:
- Sequences every MEM-stage access to the word-only synchronous data memory.
- Word accesses go straight through. Byte and half loads are extracted and extended from the read word.
- Byte and half stores run as read-modify-write.
- Drives a stall to the hazard unit while an access is in flight. Sits between the MEM-stage pipeline register and the data memory.

Parameters:
- READ_LAT, 1, cycles from mem_re asserted to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  MEM stage holds a load or store.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  encoding:
  - 000 b, 001 h, 010 w, 100 bu, 101 hu.
  - Stores use only 000, 001, 010.
- addr  in  32  byte address.
- wdata  in  32  store data from rs2.
- rdata  out  32  extended load result; valid while done=1.
- done  out  1  one-cycle pulse: access finished; the pipeline advances on this edge.
- fault  out  1  one-cycle pulse with done: misaligned access or illegal funct3.
- stall  out  1  to the hazard unit; holds F, D, E and M.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  word written to memory.
- mem_rdata  in  32  memory read data.

Behaviour:
- States: IDLE, RD, WAIT, WR, DONE. Outputs are decoded from registered state only, so mem_we cannot glitch.
- Reset:
  - State goes to IDLE; latched addr, funct3, wdata and read word are cleared.
  - All outputs are 0, including stall, done, fault, mem_re and mem_we.
- IDLE:
  - With req=0: stall=0.
  - With req=1: stall=1 combinationally. Latch addr, funct3, we and wdata on this edge, then branch:
    - Misaligned or illegal funct3 -> DONE with fault.
    - Word store -> WR.
    - Otherwise -> RD.
- Misaligned / illegal:
  - h and hu with addr[0]=1.
  - w with addr[1:0]!=0.
  - funct3 of 011, 110 or 111.
  - Loads with funct3 >= 011 other than 100 and 101.
  - In this case: no memory strobe, rdata=0, fault=1 for the DONE cycle.
- RD:
  - mem_re=1 for exactly one cycle.
  - Load the counter with READ_LAT, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata, then go to DONE (load) or WR (sub-word store).
- WR:
  - mem_we=1 for exactly one cycle, then go to DONE.
  - Word store: mem_wdata = wdata.
  - Byte store: replace the byte at lane addr[1:0] with wdata[7:0].
  - Half store: replace the half at lane addr[1] with wdata[15:0].
  - All other bytes come from the captured word.
- DONE:
  - done=1 and stall=0; return to IDLE on the next edge.
  - The incoming req belongs to the next instruction and is not sampled in DONE.
- Load extraction:
  - byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]).
  - b and h sign-extend; bu and hu zero-extend; w passes the word through.
  - rdata is held at 0 outside DONE.
- Latency from the req cycle t:
  - Load: done at t+READ_LAT+2.
  - Word store: done at t+2.
  - Sub-word store: done at t+READ_LAT+3.
  - Fault: done at t+1.
- stall = (IDLE & req) | RD | WAIT | WR.
- req, addr and wdata may change after the IDLE edge, including a flush dropping req. The latched op still completes, so a store is never half-written.
- Asynchronous reset mid-operation aborts immediately. An RMW aborted in WAIT leaves memory unmodified.
- mem_addr is driven from the latched address whenever state != IDLE, and is 0 in IDLE.

Test Plan:
- Memory word at 96 = 0xAA0BC0DD, READ_LAT=1. Loads and expected rdata:
  - lb at 96..99 -> 0xFFFFFFDD, 0xFFFFFFC0, 0x0000000B, 0xFFFFFFAA.
  - lbu at 99 -> 0x000000AA.
  - lh at 98 -> 0xFFFFAA0B.
  - lhu at 96 -> 0x0000C0DD.
  - Each done pulse occurs 3 cycles after req; stall is high for 3 cycles.
- sb with wdata=0x12345633 to addr 99 on word 0xAA0BC0DD:
  - One mem_re, then one mem_we with mem_wdata=0x330BC0DD, mem_addr=96.
  - done at t+4.
- sh with wdata=0x0000BEEF to addr 98 -> mem_wdata=0xBEEFC0DD. sw with wdata=0xCAFEF00D to addr 100 -> mem_we at t+1 with mem_wdata=0xCAFEF00D, no mem_re, done at t+2.
- Fault cases, each giving done=fault=1 at t+1 with no mem_re or mem_we:
  - lw at addr 98.
  - lh at 97.
  - Load with funct3=011.
- READ_LAT=3, lw at 96:
  - mem_rdata is sampled exactly 3 cycles after mem_re.
  - done at t+5; rdata=0xAA0BC0DD.
- Issue sb, assert reset during WAIT:
  - All outputs are 0 immediately; mem_we is never asserted; memory is unchanged.
  - The next lw after release reads the original word.
